// File: rtl/bool_func_sweep_checker.sv
// Exhaustive 3-input sweep stage: walks {a,b,c} through codes 0..7, samples the
// function-under-test output y after a settle window, and scores it against EXPECT.
module bool_func_sweep_checker #(
   parameter logic [7:0]  EXPECT = 8'hE8,
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [7:0] fail_map
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   state_t     state_next;
   logic [2:0] idx;
   logic [3:0] settle_cnt;
   logic       start_ok;
   logic       settle_end;
   logic       last_code;
   logic       mismatch;

   // start is only honoured when no sweep is in flight.
   assign start_ok   = start && ((state == IDLE) || (state == DONE));
   assign settle_end = (state == DRIVE) && (settle_cnt == SETTLE_LAST);
   assign last_code  = (idx == 3'd7);
   assign mismatch   = (state == SAMPLE) && (y != EXPECT[idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = DRIVE;
         DRIVE:   if (settle_end) state_next = SAMPLE;
         SAMPLE:  state_next = last_code ? DONE : DRIVE;
         DONE:    if (start) state_next = DRIVE;
         default: state_next = IDLE;
      endcase
   end

   // Sweep datapath; {a,b,c} mirror idx while busy and rest at 000 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= 3'd0;
         settle_cnt <= 4'd0;
         err_cnt    <= 4'd0;
         fail_map   <= 8'h00;
         done       <= 1'b0;
         a          <= 1'b0;
         b          <= 1'b0;
         c          <= 1'b0;
      end else if (start_ok) begin
         idx        <= 3'd0;
         settle_cnt <= 4'd0;
         err_cnt    <= 4'd0;
         fail_map   <= 8'h00;
         done       <= 1'b0;
         a          <= 1'b0;
         b          <= 1'b0;
         c          <= 1'b0;
      end else begin
         case (state)
            DRIVE: begin
               if (!settle_end) begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  fail_map[idx] <= 1'b1;
                  err_cnt       <= err_cnt + 4'd1;
               end
               if (last_code) begin
                  done <= 1'b1;
                  a    <= 1'b0;
                  b    <= 1'b0;
                  c    <= 1'b0;
               end else begin
                  idx        <= idx + 3'd1;
                  settle_cnt <= 4'd0;
                  {a, b, c}  <= idx + 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state == DRIVE) || (state == SAMPLE);
   assign pass = done && (err_cnt == 4'd0);

endmodule

// File: tb/tb_bool_func_sweep_checker.sv
// Directed bench: two sweep checkers (default settle / settle 1) with behavioural
// function-under-test models, checked against hand-computed results.
module tb_bool_func_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start0;
  logic       start1;
  logic [1:0] model_sel;
  logic       y0;
  logic       y1;
  logic       a0, b0, c0, busy0, done0, pass0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err_cnt0, err_cnt1;
  logic [7:0] fail_map0, fail_map1;

  int checks;
  int failures;

  bool_func_sweep_checker #(.EXPECT(8'hE8), .SETTLE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .y(y0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err_cnt0), .fail_map(fail_map0)
  );

  bool_func_sweep_checker #(.EXPECT(8'h96), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1), .fail_map(fail_map1)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // function-under-test models: 0 majority, 1 AND3, 2 stuck-at-1
  always_comb begin
    y0 = 1'b0;
    case (model_sel)
      2'd0:    y0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
      2'd1:    y0 = a0 & b0 & c0;
      default: y0 = 1'b1;
    endcase
  end
  assign y1 = a1 ^ b1 ^ c1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start0 and follows the 24-cycle sweep edge by edge; optionally
  // re-pulses start at cycles 5 and 12 to prove it is ignored while busy.
  task automatic sweep0(input string name, input logic [3:0] exp_err,
                        input logic [7:0] exp_map, input bit busy_pulses);
    @(negedge clk);
    start0 = 1'b1;
    for (int e = 0; e < 24; e++) begin
      @(posedge clk);
      @(negedge clk);
      start0 = (busy_pulses && (e == 4 || e == 11)) ? 1'b1 : 1'b0;
      chk($sformatf("%s_code_e%0d", name, e), {29'd0, a0, b0, c0}, 32'(e / 3));
      chk($sformatf("%s_busy_e%0d", name, e), {31'd0, busy0}, 32'd1);
      chk($sformatf("%s_done_e%0d", name, e), {31'd0, done0}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk({name, "_done"}, {31'd0, done0}, 32'd1);
    chk({name, "_busy_low"}, {31'd0, busy0}, 32'd0);
    chk({name, "_abc_rest"}, {29'd0, a0, b0, c0}, 32'd0);
    chk({name, "_err_cnt"}, {28'd0, err_cnt0}, {28'd0, exp_err});
    chk({name, "_fail_map"}, {24'd0, fail_map0}, {24'd0, exp_map});
    chk({name, "_pass"}, {31'd0, pass0}, {31'd0, (exp_err == 4'd0)});
  endtask

  task automatic chk_zero0(input string name);
    chk({name, "_abc"}, {29'd0, a0, b0, c0}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy0}, 32'd0);
    chk({name, "_done"}, {31'd0, done0}, 32'd0);
    chk({name, "_pass"}, {31'd0, pass0}, 32'd0);
    chk({name, "_err_cnt"}, {28'd0, err_cnt0}, 32'd0);
    chk({name, "_fail_map"}, {24'd0, fail_map0}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start0    = 1'b0;
    start1    = 1'b0;
    model_sel = 2'd0;

    // reset state
    repeat (2) @(negedge clk);
    chk_zero0("reset");
    chk("reset_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero0("idle");

    // ideal majority: clean pass
    sweep0("maj", 4'd0, 8'h00, 1'b0);
    chk("maj_done_held", {31'd0, done0}, 32'd1);

    // AND3 against majority table: codes 3,5,6 disagree
    model_sel = 2'd1;
    sweep0("and3", 4'd3, 8'h68, 1'b0);

    // stuck-at-1: codes 0,1,2,4 disagree
    model_sel = 2'd2;
    sweep0("stuck1", 4'd4, 8'h17, 1'b0);

    // start pulses while busy ignored; then start in DONE restarts cleanly
    model_sel = 2'd0;
    sweep0("busy_start", 4'd0, 8'h00, 1'b1);
    sweep0("restart", 4'd0, 8'h00, 1'b0);

    // reset mid-sweep after a failing partial run
    model_sel = 2'd2;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero0("mid_reset");
    @(negedge clk);
    chk_zero0("mid_reset_hold");
    rst_n = 1'b1;
    model_sel = 2'd0;
    sweep0("after_reset", 4'd0, 8'h00, 1'b0);

    // settle 1, XOR table: 16-cycle sweep, each code held 2 cycles
    @(negedge clk);
    start1 = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      chk($sformatf("xor_code_e%0d", e), {29'd0, a1, b1, c1}, 32'(e / 2));
      chk($sformatf("xor_busy_e%0d", e), {31'd0, busy1}, 32'd1);
      chk($sformatf("xor_done_e%0d", e), {31'd0, done1}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("xor_done", {31'd0, done1}, 32'd1);
    chk("xor_busy_low", {31'd0, busy1}, 32'd0);
    chk("xor_err_cnt", {28'd0, err_cnt1}, 32'd0);
    chk("xor_fail_map", {24'd0, fail_map1}, 32'd0);
    chk("xor_pass", {31'd0, pass1}, 32'd1);

    // start held high: one-cycle DONE then immediate new sweep
    @(negedge clk);
    start1 = 1'b1;
    repeat (17) @(negedge clk);
    chk("cont_done", {31'd0, done1}, 32'd1);
    @(negedge clk);
    chk("cont_done_one_cycle", {31'd0, done1}, 32'd0);
    chk("cont_busy_again", {31'd0, busy1}, 32'd1);
    chk("cont_code0", {29'd0, a1, b1, c1}, 32'd0);
    start1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
